// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready arbitrating mux, round-robin or fixed priority,
// packet-locked grant, one registered output beat per cycle tagged with its source channel.
`default_nettype none
module rr_arb_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
  input  logic [CHANNELS-1:0]       IN_VALID,
  input  logic [CHANNELS-1:0]       IN_LAST,
  output logic [CHANNELS-1:0]       IN_READY,
  output logic [WIDTH-1:0]          OUT_DATA,
  output logic                      OUT_VALID,
  output logic                      OUT_LAST,
  output logic [SEL_W-1:0]          OUT_CHAN,
  input  logic                      OUT_READY
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] lock_chan, lock_chan_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [SEL_W-1:0] base, hi_idx, any_idx, grant;
  logic             found_hi, found_any, grant_ok;
  logic             load_en, sel_valid, sel_last, xfer;
  logic [WIDTH-1:0] sel_data;

  assign load_en = !OUT_VALID || OUT_READY;
  assign base    = (MODE == 1) ? '0 : ptr;

  // Downward scan leaves the lowest valid index at or above base in hi_idx,
  // and the lowest valid index overall in any_idx (the wrapped-around choice).
  always_comb begin
    hi_idx    = '0;
    any_idx   = '0;
    found_hi  = 1'b0;
    found_any = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (IN_VALID[i]) begin
        any_idx   = SEL_W'(i);
        found_any = 1'b1;
        if (i >= int'(base)) begin
          hi_idx   = SEL_W'(i);
          found_hi = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (state == LOCKED) begin
      grant    = lock_chan;
      grant_ok = 1'b1;
    end else begin
      grant    = found_hi ? hi_idx : any_idx;
      grant_ok = found_any;
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    IN_READY  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) begin
        sel_valid   = IN_VALID[i];
        sel_last    = IN_LAST[i];
        sel_data    = IN_DATA[i*WIDTH +: WIDTH];
        IN_READY[i] = RESET && grant_ok && load_en;
      end
    end
  end

  assign xfer = grant_ok && sel_valid && load_en;

  always_comb begin
    state_nxt     = state;
    lock_chan_nxt = lock_chan;
    ptr_nxt       = ptr;
    if (xfer) begin
      if (state == IDLE && !sel_last) begin
        state_nxt     = LOCKED;
        lock_chan_nxt = grant;
      end else if (state == LOCKED && sel_last) begin
        state_nxt = IDLE;
      end
      if (MODE == 0 && sel_last) begin
        ptr_nxt = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      lock_chan <= '0;
      ptr       <= '0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_LAST  <= 1'b0;
      OUT_CHAN  <= '0;
    end else begin
      state     <= state_nxt;
      lock_chan <= lock_chan_nxt;
      ptr       <= ptr_nxt;
      if (xfer) begin
        OUT_VALID <= 1'b1;
        OUT_DATA  <= sel_data;
        OUT_LAST  <= sel_last;
        OUT_CHAN  <= grant;
      end else if (load_en) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
